// File: rtl/dcf77_pkg.sv
// dcf77_pkg: DCF77 time record, frame bit positions, FSM states and frame builder.
package dcf77_pkg;
  typedef struct packed {
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [2:0] weekday;
    logic [4:0] month;
    logic [7:0] year;
  } dcf77_time_t;
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_MARK, S_SPACE} dcf77_state_t;
  localparam int DCF_START = 0;
  localparam int DCF_TIME = 20;
  localparam int DCF_MIN_P = 28;
  localparam int DCF_HOUR_P = 35;
  localparam int DCF_DATE_P = 58;
  function automatic logic [58:0] build_frame(dcf77_time_t t, logic [18:0] misc);
    logic [58:0] f;
    f = '0;
    f[19:1] = misc;
    f[DCF_TIME] = 1'b1;
    f[27:21] = t.minute;
    f[DCF_MIN_P] = ^t.minute;
    f[34:29] = t.hour;
    f[DCF_HOUR_P] = ^t.hour;
    f[41:36] = t.day;
    f[44:42] = t.weekday;
    f[49:45] = t.month;
    f[57:50] = t.year;
    f[DCF_DATE_P] = ^f[57:36];
    f[DCF_START] = 1'b0;
    return f;
  endfunction
endpackage

// File: rtl/dcf77_tick_gen.sv
// dcf77_tick_gen: one-cycle tick every DIV clocks, phase restarted by i_clr.
module dcf77_tick_gen #(
  parameter int DIV = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] r_cnt;
  assign o_tick = r_cnt == W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (reset || i_clr) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/dcf77_transmitter.sv
// dcf77_transmitter: serializes a loaded BCD time/date into the DCF77 minute frame
// as a demodulated 100/200 ms pulse stream.
module dcf77_transmitter
  import dcf77_pkg::*;
#(
  parameter int CLK_FREQ  = 24_000_000,
  parameter int PULSE0_MS = 100,
  parameter int PULSE1_MS = 200,
  parameter int SECOND_MS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [18:0] misc,
  input  logic [6:0]  minute,
  input  logic [5:0]  hour,
  input  logic [5:0]  day,
  input  logic [2:0]  weekday,
  input  logic [4:0]  month,
  input  logic [7:0]  year,
  output logic        next_req,
  output logic [5:0]  second,
  output logic        tx
);
  localparam int MSW = $clog2(SECOND_MS);
  dcf77_state_t r_state, w_next;
  dcf77_time_t  w_time, r_shadow;
  logic [18:0]  r_misc;
  logic [58:0]  r_frame;
  logic [MSW-1:0] r_ms, w_ms, w_ms_inc, w_width;
  logic [5:0] w_sec;
  logic w_tick, w_req, w_copy;
  dcf77_tick_gen #(.DIV(CLK_FREQ / 1000)) u_tick (
    .clk(clk),
    .reset(reset),
    .i_clr(r_state == S_IDLE),
    .o_tick(w_tick)
  );
  assign w_time = {minute, hour, day, weekday, month, year};
  assign w_ms_inc = r_ms + 1'b1;
  assign w_width = r_frame[second] ? MSW'(PULSE1_MS) : MSW'(PULSE0_MS);
  always_comb begin
    w_next = r_state;
    w_ms = r_ms;
    w_sec = second;
    w_req = 1'b0;
    w_copy = 1'b0;
    if (!enable) begin
      w_next = S_IDLE;
      w_ms = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next = S_GAP;
          w_ms = '0;
          w_sec = 6'd59;
          w_req = 1'b1;
        end
        S_GAP: if (w_tick) begin
          w_ms = w_ms_inc;
          if (r_ms == MSW'(SECOND_MS - 1)) begin
            w_next = S_MARK;
            w_ms = '0;
            w_sec = '0;
            w_copy = 1'b1;
          end
        end
        S_MARK: if (w_tick) begin
          w_ms = w_ms_inc;
          if (w_ms_inc == w_width) w_next = S_SPACE;
        end
        S_SPACE: if (w_tick) begin
          w_ms = w_ms_inc;
          if (r_ms == MSW'(SECOND_MS - 1)) begin
            w_ms = '0;
            w_next = (second == 6'd58) ? S_GAP : S_MARK;
            w_sec = (second == 6'd58) ? 6'd59 : second + 1'b1;
            w_req = second == 6'd58;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ms <= '0;
      second <= '0;
      next_req <= 1'b0;
      tx <= 1'b0;
      r_shadow <= '0;
      r_misc <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_next;
      r_ms <= w_ms;
      second <= w_sec;
      next_req <= w_req;
      tx <= w_next == S_MARK;
      if (load) begin
        r_shadow <= w_time;
        r_misc <= misc;
      end
      // a load landing on the copy edge goes straight into the frame
      if (w_copy) r_frame <= load ? build_frame(w_time, misc) : build_frame(r_shadow, r_misc);
    end
  end
endmodule

// File: tb/tb_dcf77_transmitter.sv
// tb_dcf77_transmitter: timeline model of the DCF77 pulse stream checked every cycle,
// plus decoded-frame and pulse-width checks on directed and random loads.
module tb_dcf77_transmitter;
  localparam int DIV = 4;
  localparam int P0 = 2;
  localparam int P1 = 5;
  localparam int SMS = 20;
  localparam int SEC_CYC = SMS * DIV;
  localparam int FRAME_CYC = 60 * SEC_CYC;
  localparam logic [53:0] T1234 = {19'd0, 7'h34, 6'h12, 6'h25, 3'd3, 5'h12, 8'h09};
  localparam logic [53:0] T1235 = {19'd0, 7'h35, 6'h12, 6'h25, 3'd3, 5'h12, 8'h09};
  localparam logic [58:0] PIN1234 = {1'b1, 8'h09, 5'h12, 3'd3, 6'h25, 1'b0, 6'h12, 1'b1, 7'h34, 1'b1, 19'd0, 1'b0};
  logic clk = 1'b0;
  logic reset, enable, load;
  logic [53:0] inp;
  logic next_req, tx;
  logic [5:0] second;
  int vectors = 0;
  int fails = 0;
  dcf77_transmitter #(.CLK_FREQ(DIV * 1000), .PULSE0_MS(P0), .PULSE1_MS(P1), .SECOND_MS(SMS)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .misc(inp[53:35]),
    .minute(inp[34:28]),
    .hour(inp[27:22]),
    .day(inp[21:16]),
    .weekday(inp[15:13]),
    .month(inp[12:8]),
    .year(inp[7:0]),
    .next_req(next_req),
    .second(second),
    .tx(tx)
  );
  always #5 clk = ~clk;

  function automatic logic [58:0] frame_of(logic [53:0] v);
    logic [21:0] date;
    date = {v[7:0], v[12:8], v[15:13], v[21:16]};
    return {1'($countones(date) % 2), date, 1'($countones(v[27:22]) % 2), v[27:22],
            1'($countones(v[34:28]) % 2), v[34:28], 1'b1, v[53:35], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, got, exp, $time);
    end
  endtask

  // reference timeline: k counts cycles since the GAP that followed enable
  bit run;
  int k, p, s, c;
  logic [53:0] sh;
  logic [58:0] fr;
  logic e_tx, e_req;
  logic [5:0] e_sec;
  initial forever begin
    @(posedge clk);
    if (reset) begin
      run = 0; k = 0; sh = '0; fr = '0; e_tx = 0; e_req = 0; e_sec = 0;
    end else begin
      if (!enable) begin
        run = 0; e_tx = 0; e_req = 0;
      end else begin
        if (!run) begin run = 1; k = 0; end else k++;
        if (k >= SEC_CYC && (k - SEC_CYC) % FRAME_CYC == 0) fr = frame_of(load ? inp : sh);
        if (k < SEC_CYC) begin
          e_sec = 6'd59; e_tx = 0; e_req = (k == 0);
        end else begin
          p = (k - SEC_CYC) % FRAME_CYC;
          s = p / SEC_CYC;
          c = p % SEC_CYC;
          e_sec = 6'(s);
          e_req = (s == 59) && (c == 0);
          e_tx = (s < 59) ? (c < ((fr[s] ? P1 : P0) * DIV)) : 1'b0;
        end
      end
      if (load) sh = inp;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("tx", tx, e_tx);
      chk("second", second, e_sec);
      chk("next_req", next_req, e_req);
    end
  end

  task automatic pulse_load();
    load = 1;
    @(negedge clk);
    load = 0;
  endtask

  task automatic measure_gap(output int n, output int r);
    n = 0; r = 0;
    for (int i = 0; i < 4 * SEC_CYC; i++) begin
      @(negedge clk);
      if (tx) break;
      r += int'(next_req);
      n++;
    end
  endtask

  task automatic wait_for(input int sec);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
      @(negedge clk);
      found = (second == 6'(sec)) && tx;
    end
    chk("wait_second", found, 1);
  endtask

  task automatic capture(input bit aligned, input bit do_load, input logic [53:0] nv,
                         output logic [58:0] dec, output int w0, output int w20, output int w59, output int nrise);
    int hi[60];
    int ps;
    bit found, prev;
    dec = '0; w0 = 0; w20 = 0; w59 = 0; nrise = 0;
    found = aligned;
    ps = int'(second);
    for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
      @(negedge clk);
      found = tx && second == 0 && ps == 59;
      ps = int'(second);
    end
    chk("frame_start", found, 1);
    if (!found) return;
    foreach (hi[i]) hi[i] = 0;
    prev = 0;
    for (int cc = 0; cc < FRAME_CYC; cc++) begin
      if (cc > 0) @(negedge clk);
      if (do_load && cc == 30 * SEC_CYC + 37) begin inp = nv; load = 1; end
      else load = 0;
      hi[cc / SEC_CYC] += int'(tx);
      if (tx && !prev) nrise += (cc % SEC_CYC == 0) ? 1 : 100;
      prev = tx;
    end
    load = 0;
    for (int i = 0; i < 59; i++) dec[i] = hi[i] > ((P0 + P1) * DIV / 2);
    w0 = hi[0]; w20 = hi[20]; w59 = hi[59];
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r, w0, w20, w59, nr, bad;
    logic [58:0] d1, d2, d3, d4, d5;
    reset = 1; enable = 0; load = 0; inp = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 0);
    chk("rst_second", second, 0);
    chk("rst_next_req", next_req, 0);
    reset = 0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx || next_req || second != 0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("model_pin_1234", frame_of(T1234), PIN1234);
    chk("model_pin_zero", frame_of('0), 59'h100000);
    inp = T1234;
    pulse_load();
    enable = 1;
    measure_gap(n, r);
    chk("gap_len", n, SEC_CYC);
    chk("gap_req", r, 1);
    capture(1, 1, T1235, d1, w0, w20, w59, nr);
    chk("f1_frame", d1, PIN1234);
    chk("f1_minute", d1[27:21], 7'b0110100);
    chk("f1_bit0", d1[0], 0);
    chk("f1_bit20", d1[20], 1);
    chk("f1_bit28", d1[28], 1);
    chk("f1_bit35", d1[35], 0);
    chk("f1_bit58", d1[58], 1);
    chk("w_bit0", w0, P0 * DIV);
    chk("w_bit20", w20, P1 * DIV);
    chk("w_sec59", w59, 0);
    chk("rises", nr, 59);
    capture(0, 0, '0, d2, w0, w20, w59, nr);
    chk("f2_minute", d2[27:21], 7'b0110101);
    chk("f2_bit28", d2[28], 0);
    chk("f2_frame", d2, frame_of(T1235));
    capture(0, 0, '0, d3, w0, w20, w59, nr);
    chk("f3_repeat", d3, d2);
    wait_for(20);
    repeat (3) @(negedge clk);
    enable = 0;
    @(negedge clk);
    chk("disable_tx", tx, 0);
    repeat ($urandom_range(3, 40)) @(negedge clk);
    enable = 1;
    measure_gap(n, r);
    chk("regap_len", n, SEC_CYC);
    chk("regap_req", r, 1);
    capture(1, 0, '0, d4, w0, w20, w59, nr);
    chk("f4_after_reenable", d4, d2);
    wait_for(5);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_tx", tx, 0);
    chk("midrst_second", second, 0);
    chk("midrst_next_req", next_req, 0);
    reset = 0;
    measure_gap(n, r);
    chk("rstgap_len", n, SEC_CYC);
    capture(1, 0, '0, d5, w0, w20, w59, nr);
    chk("f5_cleared", d5, 59'h100000);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(50, 2500)) @(negedge clk);
      if ($urandom_range(0, 2) != 0) begin
        inp = 54'({$urandom(), $urandom()});
        pulse_load();
      end else begin
        enable = 0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        enable = 1;
      end
    end
    repeat (FRAME_CYC + SEC_CYC) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
